// File: rtl/control_pkg.sv
// Shared types for the multicycle control unit: state encodings, PC-source and
// ALU-B select codes, and the opcode classes produced by control_classifica.
package control_pkg;

  typedef enum logic [2:0] {
    BUSCA  = 3'd0,
    DECOD  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    ESCR   = 3'd4,
    INCPC  = 3'd5,
    PARADO = 3'd6,
    TRAP   = 3'd7
  } estado_t;

  localparam logic [1:0] FCP_ALU    = 2'b00;
  localparam logic [1:0] FCP_DESVIO = 2'b01;
  localparam logic [1:0] FCP_SALTO  = 2'b10;
  localparam logic [1:0] FCP_TRAP   = 2'b11;

  localparam logic [1:0] ULAB_UM   = 2'b00;
  localparam logic [1:0] ULAB_IMED = 2'b01;
  localparam logic [1:0] ULAB_REG  = 2'b10;

  typedef enum logic [2:0] {
    CL_REG,
    CL_IMED,
    CL_SALTO,
    CL_DESVIO,
    CL_LOAD,
    CL_STORE,
    CL_HALT,
    CL_ILEGAL
  } classe_t;

endpackage

// File: rtl/control_classifica.sv
// Combinational opcode classifier: maps an opcode onto its instruction class
// using the configurable opcode map. Anything outside the map is CL_ILEGAL.
module control_classifica
  import control_pkg::*;
#(
  parameter int          OP_W        = 4,
  parameter int unsigned OPS_REG_MAX = 5,
  parameter int unsigned OPS_IMM_MAX = 10,
  parameter int unsigned OP_JUMP     = 11,
  parameter int unsigned OP_BRANCH   = 12,
  parameter int unsigned OP_LOAD     = 13,
  parameter int unsigned OP_STORE    = 14,
  parameter int unsigned OP_HALT     = 15
) (
  input  logic [OP_W-1:0] cod_op,
  output classe_t         classe
);

  logic [31:0] op_u;

  always_comb begin
    op_u   = 32'(cod_op);
    classe = CL_ILEGAL;
    if (op_u <= OPS_REG_MAX)       classe = CL_REG;
    else if (op_u <= OPS_IMM_MAX)  classe = CL_IMED;
    else if (op_u == OP_JUMP)      classe = CL_SALTO;
    else if (op_u == OP_BRANCH)    classe = CL_DESVIO;
    else if (op_u == OP_LOAD)      classe = CL_LOAD;
    else if (op_u == OP_STORE)     classe = CL_STORE;
    else if (op_u == OP_HALT)      classe = CL_HALT;
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control FSM for the small CPU datapath (fetch/decode/execute/
// memory/write-back/PC increment/halt). Optional illegal-opcode trap: CTRL_TRAP_ILEGAL_EN.
module control_multiciclo
  import control_pkg::*;
#(
  parameter int          OP_W        = 4,
  parameter int unsigned OPS_REG_MAX = 5,
  parameter int unsigned OPS_IMM_MAX = 10,
  parameter int unsigned OP_JUMP     = 11,
  parameter int unsigned OP_BRANCH   = 12,
  parameter int unsigned OP_LOAD     = 13,
  parameter int unsigned OP_STORE    = 14,
  parameter int unsigned OP_HALT     = 15,
  parameter int unsigned ULA_ADD     = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] CodOP,
  input  logic            MemPronta,
  output logic            EscLR,
  output logic            EscCP,
  output logic            EscCondCP,
  output logic [1:0]      FonteCP,
  output logic [OP_W-1:0] ULA_OP,
  output logic            ULA_A,
  output logic [1:0]      ULA_B,
  output logic            EscReg,
  output logic            MemParaReg,
  output logic            LerMem,
  output logic            EscMem,
  output logic [2:0]      Estado
`ifdef CTRL_TRAP_ILEGAL_EN
  ,
  output logic            Excecao
`endif
);

  localparam logic [OP_W-1:0] ULA_ADD_C = OP_W'(ULA_ADD);

  estado_t         estado, prox;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] cls_in;
  classe_t         classe;

  // In DECOD the live opcode decides the branch; afterwards the latched copy rules.
  assign cls_in = (estado == DECOD) ? CodOP : op_q;

  control_classifica #(
    .OP_W        (OP_W),
    .OPS_REG_MAX (OPS_REG_MAX),
    .OPS_IMM_MAX (OPS_IMM_MAX),
    .OP_JUMP     (OP_JUMP),
    .OP_BRANCH   (OP_BRANCH),
    .OP_LOAD     (OP_LOAD),
    .OP_STORE    (OP_STORE),
    .OP_HALT     (OP_HALT)
  ) u_classifica (
    .cod_op (cls_in),
    .classe (classe)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado <= BUSCA;
      op_q   <= '0;
    end else begin
      estado <= prox;
      if (estado == DECOD) op_q <= CodOP;
    end
  end

  always_comb begin
    prox       = estado;
    EscLR      = 1'b0;
    EscCP      = 1'b0;
    EscCondCP  = 1'b0;
    FonteCP    = FCP_ALU;
    ULA_OP     = '0;
    ULA_A      = 1'b0;
    ULA_B      = ULAB_UM;
    EscReg     = 1'b0;
    MemParaReg = 1'b0;
    LerMem     = 1'b0;
    EscMem     = 1'b0;
    Estado     = estado;
`ifdef CTRL_TRAP_ILEGAL_EN
    Excecao    = 1'b0;
`endif

    case (estado)
      BUSCA: begin
        LerMem = 1'b1;
        EscLR  = MemPronta;
        prox   = MemPronta ? DECOD : BUSCA;
      end

      DECOD: begin
        if (classe == CL_HALT)        prox = PARADO;
`ifdef CTRL_TRAP_ILEGAL_EN
        else if (classe == CL_ILEGAL) prox = TRAP;
`endif
        else                          prox = EXEC;
      end

      EXEC: begin
        case (classe)
          CL_REG: begin
            ULA_A  = 1'b1;
            ULA_B  = ULAB_REG;
            ULA_OP = op_q;
            prox   = ESCR;
          end
          CL_IMED: begin
            ULA_A  = 1'b1;
            ULA_B  = ULAB_IMED;
            ULA_OP = op_q;
            prox   = ESCR;
          end
          CL_SALTO: begin
            EscCP   = 1'b1;
            FonteCP = FCP_SALTO;
            prox    = BUSCA;
          end
          CL_DESVIO: begin
            EscCondCP = 1'b1;
            ULA_A     = 1'b1;
            ULA_B     = ULAB_REG;
            ULA_OP    = op_q;
            FonteCP   = FCP_DESVIO;
            prox      = BUSCA;
          end
          CL_LOAD, CL_STORE: begin
            ULA_A  = 1'b1;
            ULA_B  = ULAB_IMED;
            ULA_OP = ULA_ADD_C;
            prox   = MEM;
          end
          default: prox = INCPC;
        endcase
      end

      MEM: begin
        // Request held steady across wait states until memory answers.
        if (classe == CL_STORE) EscMem = 1'b1;
        else                    LerMem = 1'b1;
        if (MemPronta) prox = (classe == CL_STORE) ? INCPC : ESCR;
      end

      ESCR: begin
        EscReg     = 1'b1;
        MemParaReg = (classe == CL_LOAD);
        ULA_OP     = op_q;
        prox       = INCPC;
      end

      INCPC: begin
        EscCP  = 1'b1;
        ULA_OP = ULA_ADD_C;
        prox   = BUSCA;
      end

      PARADO: prox = PARADO;

`ifdef CTRL_TRAP_ILEGAL_EN
      TRAP: begin
        Excecao = 1'b1;
        EscCP   = 1'b1;
        FonteCP = FCP_TRAP;
        prox    = BUSCA;
      end
`endif

      default: prox = BUSCA;
    endcase

    // Reset silences the datapath immediately so an aborted write never lands.
    if (RST) begin
      EscLR      = 1'b0;
      EscCP      = 1'b0;
      EscCondCP  = 1'b0;
      FonteCP    = '0;
      ULA_OP     = '0;
      ULA_A      = 1'b0;
      ULA_B      = '0;
      EscReg     = 1'b0;
      MemParaReg = 1'b0;
      LerMem     = 1'b0;
      EscMem     = 1'b0;
      Estado     = '0;
`ifdef CTRL_TRAP_ILEGAL_EN
      Excecao    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo (OP_W = 5): directed instruction
// sequences queue per-cycle expectations, a negedge monitor compares them.
module tb_control_multiciclo;

  localparam int OP_W = 5;

  logic            CLK = 1'b0;
  logic            RST;
  logic [OP_W-1:0] CodOP;
  logic            MemPronta;
  logic            EscLR, EscCP, EscCondCP, ULA_A, EscReg, MemParaReg, LerMem, EscMem;
  logic [1:0]      FonteCP, ULA_B;
  logic [OP_W-1:0] ULA_OP;
  logic [2:0]      Estado;
  logic            exc;

  control_multiciclo #(.OP_W(OP_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CodOP      (CodOP),
    .MemPronta  (MemPronta),
    .EscLR      (EscLR),
    .EscCP      (EscCP),
    .EscCondCP  (EscCondCP),
    .FonteCP    (FonteCP),
    .ULA_OP     (ULA_OP),
    .ULA_A      (ULA_A),
    .ULA_B      (ULA_B),
    .EscReg     (EscReg),
    .MemParaReg (MemParaReg),
    .LerMem     (LerMem),
    .EscMem     (EscMem),
    .Estado     (Estado)
`ifdef CTRL_TRAP_ILEGAL_EN
    ,
    .Excecao    (exc)
`endif
  );

`ifndef CTRL_TRAP_ILEGAL_EN
  assign exc = 1'b0;
`endif

  always #5 CLK = ~CLK;

  logic [20:0] got;
  assign got = {Estado, EscLR, EscCP, EscCondCP, FonteCP, ULA_OP, ULA_A, ULA_B,
                EscReg, MemParaReg, LerMem, EscMem, exc};

  logic [20:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [20:0] mk(input logic [2:0] st, input logic lr, input logic cp,
                                     input logic ccp, input logic [1:0] fcp,
                                     input logic [4:0] uop, input logic ua,
                                     input logic [1:0] ub, input logic er, input logic mr,
                                     input logic lm, input logic em, input logic ex);
    return {st, lr, cp, ccp, fcp, uop, ua, ub, er, mr, lm, em, ex};
  endfunction

  task automatic step(input logic rst, input logic [OP_W-1:0] cod, input logic mp,
                      input logic [20:0] e, input string nm);
    RST       = rst;
    CodOP     = cod;
    MemPronta = mp;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      logic [20:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got=%h required=%h (t=%0t)", nm, got, e, $time);
      end
    end
  end

  localparam logic [OP_W-1:0] X = 5'h1F;

  initial begin
    logic [20:0] eZERO, eBUSCA, eBUSW, eDECOD, eINCPC, eLSEX, ePARADO;
    eZERO   = mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    eBUSCA  = mk(0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    eBUSW   = mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    eDECOD  = mk(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    eINCPC  = mk(5, 0, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    eLSEX   = mk(2, 0, 0, 0, 2'b00, 0, 1, 2'b01, 0, 0, 0, 0, 0);
    ePARADO = mk(6, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);

    RST = 1'b1; CodOP = '0; MemPronta = 1'b1;
    @(posedge CLK); #1;

    step(1, 0, 1, eZERO, "rst_c0");
    step(1, 0, 1, eZERO, "rst_c1");

    // register ALU op 3
    step(0, X, 1, eBUSCA, "reg_busca");
    step(0, 3, 1, eDECOD, "reg_decod");
    step(0, X, 1, mk(2, 0, 0, 0, 2'b00, 3, 1, 2'b10, 0, 0, 0, 0, 0), "reg_exec");
    step(0, X, 1, mk(4, 0, 0, 0, 2'b00, 3, 0, 2'b00, 1, 0, 0, 0, 0), "reg_escr");
    step(0, X, 1, eINCPC, "reg_incpc");

    // immediate op 7, one fetch wait
    step(0, X, 0, eBUSW, "imm_busca_wait");
    step(0, X, 1, eBUSCA, "imm_busca");
    step(0, 7, 1, eDECOD, "imm_decod");
    step(0, X, 1, mk(2, 0, 0, 0, 2'b00, 7, 1, 2'b01, 0, 0, 0, 0, 0), "imm_exec");
    step(0, X, 1, mk(4, 0, 0, 0, 2'b00, 7, 0, 2'b00, 1, 0, 0, 0, 0), "imm_escr");
    step(0, X, 1, eINCPC, "imm_incpc");

    // load 13, three memory wait cycles
    step(0, X, 1, eBUSCA, "ld_busca");
    step(0, 13, 1, eDECOD, "ld_decod");
    step(0, X, 1, eLSEX, "ld_exec");
    for (int i = 0; i < 3; i++)
      step(0, X, 0, mk(3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0), "ld_mem_wait");
    step(0, X, 1, mk(3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0), "ld_mem_ready");
    step(0, X, 1, mk(4, 0, 0, 0, 2'b00, 13, 0, 2'b00, 1, 1, 0, 0, 0), "ld_escr");
    step(0, X, 1, eINCPC, "ld_incpc");

    // store 14, one memory wait cycle
    step(0, X, 1, eBUSCA, "st_busca");
    step(0, 14, 1, eDECOD, "st_decod");
    step(0, X, 1, eLSEX, "st_exec");
    step(0, X, 0, mk(3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0), "st_mem_wait");
    step(0, X, 1, mk(3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0), "st_mem_ready");
    step(0, X, 1, eINCPC, "st_incpc");

    // jump 11 then branch 12
    step(0, X, 1, eBUSCA, "jmp_busca");
    step(0, 11, 1, eDECOD, "jmp_decod");
    step(0, X, 1, mk(2, 0, 1, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0), "jmp_exec");
    step(0, X, 1, eBUSCA, "br_busca");
    step(0, 12, 1, eDECOD, "br_decod");
    step(0, X, 1, mk(2, 0, 0, 1, 2'b01, 12, 1, 2'b10, 0, 0, 0, 0, 0), "br_exec");

    // unmapped opcode 10110
    step(0, X, 1, eBUSCA, "il_busca");
    step(0, 5'b10110, 1, eDECOD, "il_decod");
`ifdef CTRL_TRAP_ILEGAL_EN
    step(0, X, 1, mk(7, 0, 1, 0, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 1), "il_trap");
`else
    step(0, X, 1, mk(2, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0), "il_exec_nop");
    step(0, X, 1, eINCPC, "il_incpc");
`endif

    // reset during a stalled store aborts the write
    step(0, X, 1, eBUSCA, "ab_busca");
    step(0, 14, 1, eDECOD, "ab_decod");
    step(0, X, 1, eLSEX, "ab_exec");
    step(0, X, 0, mk(3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0), "ab_mem_wait");
    step(1, X, 0, eZERO, "ab_rst");
    step(0, X, 1, eBUSCA, "ab_busca_after");

    // halt 15, parked for 20 cycles, released by reset
    step(0, 15, 1, eDECOD, "halt_decod");
    for (int i = 0; i < 20; i++)
      step(0, 5'(i), logic'(i[0]), ePARADO, "halt_parked");
    step(1, X, 1, eZERO, "halt_rst");
    step(0, X, 1, eBUSCA, "halt_released");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Parametrised multicycle control unit for the team's small CPU datapath. Next generation of the single-opcode-width control FSM.
- Explicit state machine (fetch, decode, execute, memory, write-back, PC increment, halt) driving PC, IR, register-file, ALU-mux and memory enables.
- Adds load/store, memory wait-state handshake, halt, configurable opcode width and opcode map.
- Sits between the IR opcode field and the datapath/memory interface.

Parameters:
- OP_W, 4: opcode width.
- OPS_REG_MAX, 5: opcodes 0..OPS_REG_MAX are register-register ALU ops.
- OPS_IMM_MAX, 10: opcodes OPS_REG_MAX+1..OPS_IMM_MAX are immediate ALU ops.
- OP_JUMP, 11: unconditional jump opcode.
- OP_BRANCH, 12: conditional branch opcode.
- OP_LOAD, 13: load opcode.
- OP_STORE, 14: store opcode.
- OP_HALT, 15: halt opcode.
- ULA_ADD, 0: ALU operation code for add, used for address calc and PC+1.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: synchronous reset, active high.
- CodOP, in, OP_W: opcode field from IR.
- MemPronta, in, 1: memory ready; completes the current read/write in the same cycle.
- EscLR, out, 1: IR write.
- EscCP, out, 1: PC write.
- EscCondCP, out, 1: conditional PC write (branch).
- FonteCP, out, 2: PC source. 00 = ALU, 01 = branch target, 10 = jump, 11 = trap vector.
- ULA_OP, out, OP_W: ALU operation.
- ULA_A, out, 1: ALU A select. 0 = PC, 1 = register.
- ULA_B, out, 2: ALU B select. 00 = const 1, 01 = immediate, 10 = register.
- EscReg, out, 1: register-file write.
- MemParaReg, out, 1: write-back source. 1 = memory data.
- LerMem, out, 1: memory read request.
- EscMem, out, 1: memory write request.
- Estado, out, 3: current state encoding, for debug.
- Excecao, out, 1: illegal-opcode flag. Exists only with the optional feature.

Behaviour:
- Reset
  - RST high at a rising edge → state BUSCA, internal opcode register op_q = 0.
  - While RST is high all outputs are forced to 0.
  - RST mid-instruction aborts it; no pending write is completed.
- Output style
  - Outputs are Moore decodes of the state plus op_q; MemPronta gates the handshake strobes.
  - Any output not listed for a state is 0.
- State encodings: BUSCA = 0, DECOD = 1, EXEC = 2, MEM = 3, ESCR = 4, INCPC = 5, PARADO = 6, TRAP = 7.
- BUSCA
  - LerMem = 1; EscLR = MemPronta.
  - Stays in BUSCA while MemPronta = 0; goes to DECOD when MemPronta = 1.
- DECOD
  - op_q ← CodOP. CodOP is sampled only here and ignored in every other state.
  - Next state EXEC.
  - If CodOP = OP_HALT, next state is PARADO instead.
- EXEC, by class of op_q
  - Register op: ULA_A = 1, ULA_B = 10, ULA_OP = op_q → ESCR.
  - Immediate op: ULA_A = 1, ULA_B = 01, ULA_OP = op_q → ESCR.
  - Jump: EscCP = 1, FonteCP = 10 → BUSCA.
  - Branch: EscCondCP = 1, ULA_A = 1, ULA_B = 10, ULA_OP = op_q, FonteCP = 01 → BUSCA.
  - Load or store: ULA_A = 1, ULA_B = 01, ULA_OP = ULA_ADD → MEM.
  - Opcode outside the map (possible only when OP_W > 4): no writes → INCPC (NOP).
- MEM
  - Load: LerMem = 1. Store: EscMem = 1.
  - Holds while MemPronta = 0; requests stay asserted and stable.
  - On MemPronta: load → ESCR, store → INCPC.
- ESCR
  - EscReg = 1; MemParaReg = 1 for load, otherwise 0; ULA_OP = op_q.
  - Next state INCPC.
- INCPC
  - EscCP = 1, ULA_A = 0, ULA_B = 00, ULA_OP = ULA_ADD, FonteCP = 00.
  - Next state BUSCA.
- PARADO: all outputs 0; stays until RST.
- Latency with zero wait states (MemPronta always 1):
  - ALU op: 5 cycles. Jump/branch: 3. Load: 6. Store: 5. Halt: 2 cycles, then parked in PARADO.
  - Each memory wait cycle adds 1.
- Exclusivity: at most one of EscCP/EscCondCP per cycle; LerMem and EscMem are never both 1.

Optional Feature:
- Macro: CTRL_TRAP_ILEGAL_EN.
- Defined: an unmapped opcode in DECOD → TRAP for one cycle.
  - TRAP drives Excecao = 1, EscCP = 1, FonteCP = 11, then → BUSCA.
  - Excecao port exists.
- Undefined: TRAP state is unreachable; unmapped opcodes execute as NOP through INCPC; Excecao port is absent.

Decomposition:
- Package control_pkg:
  - state enum (encodings above);
  - FonteCP codes (FCP_ALU, FCP_DESVIO, FCP_SALTO, FCP_TRAP);
  - ULA_B codes (ULAB_UM, ULAB_IMED, ULAB_REG);
  - opcode-class enum.
- Sub-module control_classifica: combinational, maps opcode → class using the parameters. Used in DECOD/EXEC.

Test Plan:
- RST = 1 for 2 cycles, then 0, MemPronta = 1 → Estado = 0, all outputs 0 during reset; first cycle after release LerMem = 1, EscLR = 1.
- CodOP = 0011, MemPronta = 1 → states 0,1,2,4,5,0. ULA_B = 10 in EXEC, EscReg = 1 in ESCR, EscCP = 1 with ULA_B = 00 in INCPC. 5 cycles total.
- CodOP = 1101 (load), MemPronta low for 3 cycles in MEM → LerMem held for 4 cycles, then ESCR with MemParaReg = 1. 9 cycles total.
- CodOP = 1011 then 1100 → jump: EscCP = 1, FonteCP = 10 in cycle 3. Branch: EscCondCP = 1, FonteCP = 01, EscCP = 0.
- CodOP = 1111 → PARADO by cycle 3; stays there 20 cycles with all outputs 0; RST releases it to BUSCA.
- OP_W = 5, CodOP = 10110 → with CTRL_TRAP_ILEGAL_EN: Excecao = 1, FonteCP = 11 for 1 cycle; without it: INCPC with EscCP = 1, FonteCP = 00, EscReg never asserted.
